// File: rtl/seq_divider.sv
// Multicycle signed 32-bit restoring divider for MIPS DIV.
// Produces a truncating quotient (LO) and a remainder that takes the dividend's sign (HI).
module seq_divider (
    input  logic        clk,
    input  logic        reset,
    input  logic        div_start,
    input  logic [31:0] div_a,
    input  logic [31:0] div_b,
    output logic [31:0] div_hi,
    output logic [31:0] div_lo,
    output logic        div_busy,
    output logic        div_done,
    output logic        div_zero
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [W-1:0]    rem, rem_n;
    logic [W-1:0]    dq, dq_n;
    logic [W-1:0]    dvs, dvs_n;
    logic            sign_q, sign_q_n;
    logic            sign_r, sign_r_n;
    logic [W-1:0]    hi_n, lo_n;
    logic            busy_n, done_n, zero_n;
    logic [W:0]      rem_sh, trial;

    // Next-state and datapath; the remainder never exceeds 32 bits once restored.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        rem_n    = rem;
        dq_n     = dq;
        dvs_n    = dvs;
        sign_q_n = sign_q;
        sign_r_n = sign_r;
        hi_n     = div_hi;
        lo_n     = div_lo;
        busy_n   = 1'b0;
        done_n   = 1'b0;
        zero_n   = 1'b0;
        rem_sh   = {rem, dq[W-1]};
        trial    = rem_sh - {1'b0, dvs};

        case (state)
            IDLE: begin
                if (div_start) begin
                    if (div_b == '0) begin
                        zero_n = 1'b1;
                    end else begin
                        dq_n     = div_a[W-1] ? W'(-div_a) : div_a;
                        dvs_n    = div_b[W-1] ? W'(-div_b) : div_b;
                        sign_q_n = div_a[W-1] ^ div_b[W-1];
                        sign_r_n = div_a[W-1];
                        rem_n    = '0;
                        cnt_n    = '0;
                        busy_n   = 1'b1;
                        state_n  = RUN;
                    end
                end
            end
            RUN: begin
                busy_n = 1'b1;
                if (!trial[W]) begin
                    rem_n = trial[W-1:0];
                    dq_n  = {dq[W-2:0], 1'b1};
                end else begin
                    rem_n = rem_sh[W-1:0];
                    dq_n  = {dq[W-2:0], 1'b0};
                end
                cnt_n = cnt + CW'(1);
                if (cnt == CW'(W - 1)) begin
                    state_n = FIX;
                end
            end
            FIX: begin
                lo_n    = sign_q ? W'(-dq) : dq;
                hi_n    = sign_r ? W'(-rem) : rem;
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            rem      <= '0;
            dq       <= '0;
            dvs      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            div_hi   <= '0;
            div_lo   <= '0;
            div_busy <= 1'b0;
            div_done <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            rem      <= rem_n;
            dq       <= dq_n;
            dvs      <= dvs_n;
            sign_q   <= sign_q_n;
            sign_r   <= sign_r_n;
            div_hi   <= hi_n;
            div_lo   <= lo_n;
            div_busy <= busy_n;
            div_done <= done_n;
            div_zero <= zero_n;
        end
    end

endmodule
